zrl_bit_packer: RTL and testbench
=================================

// Module: zrl_bit_packer
// PURPOSE
//   Sits directly downstream of the ZRL compressor stage.
//   Concatenates its variable-length, MSB-aligned codewords (1..68 bits) into a dense stream of fixed 64-bit words for the memory/link writer.
//   Packet framing (sop/eop) is preserved. At each eop the final partial word is zero-padded and its valid-bit count is reported.
// PARAMETERS
//   CODE_W  68   input codeword bus width (max codeword length)
//   SIZE_W  7    width of codeword size field
//   OUT_W   64   output word width; BUF_W must be a multiple of it
//   BUF_W   256  accumulation buffer width in bits (BUF_W/OUT_W = NSLOT = 4 slots)
// PORTS
//   clk          in   1       clock
//   rst_n        in   1       synchronous active-low reset
//   data_i       in   68      codeword, MSB-aligned; bits below size_i ignored
//   size_i       in   7       codeword length in bits, 0..68
//   sop_i        in   1       codeword is first of packet
//   eop_i        in   1       codeword is last of packet
//   valid_i      in   1       codeword present; always accepted (no stall to source)
//   ready_o      out  1       headroom for two more codewords; upstream gates new raw input on it
//   data_o       out  64      packed output word
//   valid_o      out  1       data_o valid
//   sop_o        out  1       word holds first bit of a packet
//   eop_o        out  1       word holds last bit of a packet
//   bits_o       out  7       valid bits in data_o from MSB (1..64; 64 unless eop_o)
//   ready_i      in   1       downstream accepts word when valid_o & ready_i
//   overflow_o   out  1       sticky: a codeword was dropped for lack of space
//   proto_err_o  out  1       sticky: sop_i seen while fill not slot-aligned, or size_i > 68
// BEHAVIOUR
//   - State:
//     - buf_q[BUF_W-1:0], filled MSB-first.
//     - fill_q (0..BUF_W).
//     - Per-slot tags: sop_t[NSLOT], eop_t[NSLOT], lbits_t[NSLOT] (7b). Slot 0 = buf_q[BUF_W-1 -: 64].
//   - Reset (rst_n=0 at posedge): buf_q, fill_q, all tags, overflow_o and proto_err_o go to 0.
//     - Hence valid_o=0, sop_o=0, eop_o=0, bits_o=0, data_o=0, ready_o=1.
//     - Reset mid-packet discards all buffered bits.
//   - valid_o = (fill_q >= OUT_W). data_o = slot 0. sop_o/eop_o/bits_o = slot-0 tags, all gated by valid_o.
//     - Outputs are derived combinationally from registered state only.
//   - ready_o = (fill_q <= BUF_W - 2*CODE_W), i.e. fill_q <= 120.
//     - This covers the one in-flight beat of the 1-cycle upstream stage.
//   - Per cycle, pop first, then append:
//     - pop = valid_o & ready_i. f1 = fill_q - (pop ? 64 : 0). Buffer and tags shift up one slot on pop.
//     - Append (valid_i): the codeword's top size_i bits are ORed in at bit position BUF_W-1-f1. f2 = f1 + size_i.
//     - sop_i: sets sop_t of the slot at index f1/64.
//     - eop_i:
//       - Sets eop_t on the slot holding bit f2-1 (slot (f2-1)/64).
//       - That slot's lbits_t = ((f2-1) mod 64) + 1.
//       - fill is then rounded up to the next multiple of 64; pad bits are 0.
//       - eop_i with size_i=0 and f1 aligned: no new slot; eop_t is set on the last occupied slot, keeping its lbits. If the buffer is empty, nothing happens.
//     - Non-eop slots keep lbits_t=64.
//   - Overflow: if f2 (before rounding) > BUF_W, the beat is dropped whole and overflow_o is set.
//     - fill and tags stay at their pop-only values.
//   - Latency: a codeword completing a slot at edge N makes that word visible on data_o from N+1.
//     - Simultaneous pop + append in one cycle is required, giving one word per cycle sustained.
//   - sop_i with f1 mod 64 != 0: proto_err_o is set. The codeword is still packed and the slot tagged.
//   - size_i > 68: proto_err_o is set and the beat is treated as size 68.
//   - sop_i & eop_i on the same beat is a legal single-beat packet.
//   - Bits beyond size_i in data_i are masked to 0 before the OR.
// STRUCTURE
//   - Shared package zrl_pkg: CODE_W, SIZE_W, OUT_W constants and typedef zrl_code_t {data, size, sop, eop, valid}.
//     zrl_code_t is shared with the compressor stage.
//   - One sub-module, zrl_align_shifter: combinational right-shift of the masked 68-bit code by f1 into BUF_W bits.
//   - Tag/slot logic and control stay in zrl_bit_packer.
// TESTING
//   1. Reset with valid_i=1 held -> all outputs 0, ready_o=1, fill 0 on the first cycle after release.
//   2. One beat: sop=eop=1, size=8, data=0x40<<60, ready_i=1 -> next cycle data_o=0x4000_0000_0000_0000.
//      Also sop_o=eop_o=1, bits_o=8, valid_o for exactly 1 cycle.
//   3. 8 beats of size 8, data=0xAB<<60, sop on the first, eop on the last -> single word 0xABAB_ABAB_ABAB_ABAB.
//      Also bits_o=64, sop_o=eop_o=1, no padding word.
//   4. Sizes 66 then 66+eop -> 3 words: bits_o 64, 64, 4; word 2 low 60 bits = 0; eop_o only on word 2.
//   5. ready_i=0, 68-bit beats each cycle -> ready_o falls after beat 2 (fill 136); beat 3 is accepted (fill 204).
//      Beat 4 raises overflow_o and fill stays 204. Releasing ready_i then drains words in order.
//   6. sop_i at fill 8 (no prior eop) -> proto_err_o=1 and stays 1 until reset; data is still packed contiguously.

Source files
------------

// File: rtl/zrl_pkg.sv
// Constants and types shared by the ZRL compressor and bit packer stages.
// mask_code keeps only the top 'size' bits of an MSB-aligned codeword.
package zrl_pkg;

    localparam int CODE_W = 68;
    localparam int SIZE_W = 7;
    localparam int OUT_W  = 64;
    localparam int BUF_W  = 256;
    localparam int NSLOT  = BUF_W / OUT_W;
    localparam int FILL_W = 9;

    typedef struct packed {
        logic [CODE_W-1:0] data;
        logic [SIZE_W-1:0] size;
        logic              sop;
        logic              eop;
        logic              valid;
    } zrl_code_t;

    function automatic logic [CODE_W-1:0] mask_code(input logic [CODE_W-1:0] data,
                                                    input logic [SIZE_W-1:0] size);
        return data & ~({CODE_W{1'b1}} >> size);
    endfunction

endpackage

// File: rtl/zrl_bit_packer_if.sv
// Codeword input stream and packed-word output stream of the bit packer.
// The slave modport is the packer's view; master is the surrounding logic.
interface zrl_bit_packer_if;
    import zrl_pkg::*;

    logic [CODE_W-1:0] data_i;
    logic [SIZE_W-1:0] size_i;
    logic              sop_i;
    logic              eop_i;
    logic              valid_i;
    logic              ready_o;
    logic [OUT_W-1:0]  data_o;
    logic              valid_o;
    logic              sop_o;
    logic              eop_o;
    logic [SIZE_W-1:0] bits_o;
    logic              ready_i;
    logic              overflow_o;
    logic              proto_err_o;

    modport slave (
        input  data_i, size_i, sop_i, eop_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, sop_o, eop_o, bits_o, overflow_o, proto_err_o
    );

    modport master (
        output data_i, size_i, sop_i, eop_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, sop_o, eop_o, bits_o, overflow_o, proto_err_o
    );

endinterface

// File: rtl/zrl_align_shifter.sv
// Places a masked codeword into the accumulation buffer frame, starting
// 'offset' bits below the buffer MSB.
module zrl_align_shifter
    import zrl_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic [FILL_W-1:0] offset,
    output logic [BUF_W-1:0]  shifted
);

    logic [BUF_W-1:0] wide;

    assign wide    = {code, {(BUF_W-CODE_W){1'b0}}};
    assign shifted = wide >> offset;

endmodule

// File: rtl/zrl_bit_packer.sv
// Packs variable-length MSB-aligned codewords into dense 64-bit words,
// tagging each 64-bit slot with packet framing and valid-bit count.
module zrl_bit_packer
    import zrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    zrl_bit_packer_if.slave  bus
);

    localparam logic [FILL_W-1:0]  OUT_F   = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0]  READY_F = FILL_W'(BUF_W - 2*CODE_W);
    localparam logic [FILL_W:0]    BUF_F   = (FILL_W+1)'(BUF_W);
    localparam logic [SIZE_W-1:0]  FULL_LB = SIZE_W'(OUT_W);

    logic [BUF_W-1:0]              buf_q, buf_n;
    logic [FILL_W-1:0]             fill_q, fill_n;
    logic [NSLOT-1:0]              sop_t, sop_n, eop_t, eop_n;
    logic [NSLOT-1:0][SIZE_W-1:0]  lbits_t, lbits_n;
    logic                          overflow_q, overflow_n, proto_err_q, proto_err_n;

    zrl_code_t          code;
    logic               valid_w, pop, oversize, drop, accept;
    logic [SIZE_W-1:0]  sz;
    logic [FILL_W-1:0]  f1;
    logic [FILL_W:0]    f2;
    logic [BUF_W-1:0]   shifted;

    assign code     = '{data: bus.data_i, size: bus.size_i, sop: bus.sop_i,
                        eop: bus.eop_i, valid: bus.valid_i};
    assign valid_w  = fill_q >= OUT_F;
    assign pop      = valid_w & bus.ready_i;
    assign oversize = code.size > SIZE_W'(CODE_W);
    assign sz       = oversize ? SIZE_W'(CODE_W) : code.size;
    assign f1       = pop ? fill_q - OUT_F : fill_q;
    assign f2       = {1'b0, f1} + (FILL_W+1)'(sz);
    assign drop     = code.valid & (f2 > BUF_F);
    assign accept   = code.valid & ~drop;

    zrl_align_shifter u_shift (
        .code    (mask_code(code.data, sz)),
        .offset  (f1),
        .shifted (shifted)
    );

    assign bus.valid_o     = valid_w;
    assign bus.data_o      = valid_w ? buf_q[BUF_W-1 -: OUT_W] : '0;
    assign bus.sop_o       = valid_w & sop_t[0];
    assign bus.eop_o       = valid_w & eop_t[0];
    assign bus.bits_o      = valid_w ? lbits_t[0] : '0;
    assign bus.ready_o     = fill_q <= READY_F;
    assign bus.overflow_o  = overflow_q;
    assign bus.proto_err_o = proto_err_q;

    // Pop shifts every slot up by one, then the accepted codeword is merged
    // at f1; a dropped beat leaves the pop-only state in place.
    always_comb begin
        logic [1:0] idx;
        logic [7:0] last;
        idx         = '0;
        last        = '0;
        buf_n       = pop ? {buf_q[BUF_W-OUT_W-1:0], {OUT_W{1'b0}}} : buf_q;
        sop_n       = pop ? (sop_t >> 1) : sop_t;
        eop_n       = pop ? (eop_t >> 1) : eop_t;
        lbits_n     = pop ? (lbits_t >> SIZE_W) : lbits_t;
        fill_n      = f1;
        overflow_n  = overflow_q | drop;
        proto_err_n = proto_err_q | (code.valid & oversize);

        if (accept) begin
            buf_n  = buf_n | shifted;
            fill_n = f2[FILL_W-1:0];
            for (int i = 0; i < NSLOT; i++) begin
                if (3'(i) >= f1[FILL_W-1:6]) lbits_n[i] = FULL_LB;
            end
            if (code.sop) begin
                if (f1[5:0] != 6'd0) proto_err_n = 1'b1;
                if (!f1[FILL_W-1]) sop_n[f1[7:6]] = 1'b1;
            end
            // A zero-length eop on an aligned fill closes the previous slot
            // without touching its bit count; on an empty buffer it is a no-op.
            if (code.eop && f2 != '0) begin
                if (sz == '0 && f1[5:0] == 6'd0) begin
                    idx        = 2'(f1[FILL_W-1:6] - 3'd1);
                    eop_n[idx] = 1'b1;
                end else begin
                    last         = 8'(f2 - 1'b1);
                    idx          = last[7:6];
                    eop_n[idx]   = 1'b1;
                    lbits_n[idx] = {1'b0, last[5:0]} + 1'b1;
                    fill_n       = (f2[FILL_W-1:0] + FILL_W'(63)) & ~FILL_W'(63);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q       <= '0;
            fill_q      <= '0;
            sop_t       <= '0;
            eop_t       <= '0;
            lbits_t     <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            buf_q       <= buf_n;
            fill_q      <= fill_n;
            sop_t       <= sop_n;
            eop_t       <= eop_n;
            lbits_t     <= lbits_n;
            overflow_q  <= overflow_n;
            proto_err_q <= proto_err_n;
        end
    end

endmodule

// File: tb/tb_zrl_bit_packer.sv
// Directed bench for zrl_bit_packer with hand-computed expected words.
module tb_zrl_bit_packer;
    import zrl_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    zrl_bit_packer_if bus ();

    zrl_bit_packer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [CODE_W-1:0] data, input logic [SIZE_W-1:0] size,
                                  input logic sop, input logic eop);
        bus.data_i  = data;
        bus.size_i  = size;
        bus.sop_i   = sop;
        bus.eop_i   = eop;
        bus.valid_i = 1'b1;
        next_cycle();
        bus.valid_i = 1'b0;
        bus.sop_i   = 1'b0;
        bus.eop_i   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.data_i  = {CODE_W{1'b1}};
        bus.size_i  = 7'd68;
        bus.sop_i   = 1'b1;
        bus.eop_i   = 1'b1;
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;

        // Reset held with a live codeword on the input
        next_cycle();
        next_cycle();
        check_output("rst_valid", 64'(bus.valid_o), 64'd0);
        check_output("rst_data", bus.data_o, 64'd0);
        check_output("rst_sop", 64'(bus.sop_o), 64'd0);
        check_output("rst_eop", 64'(bus.eop_o), 64'd0);
        check_output("rst_bits", 64'(bus.bits_o), 64'd0);
        check_output("rst_ready", 64'(bus.ready_o), 64'd1);
        check_output("rst_ovf", 64'(bus.overflow_o), 64'd0);
        check_output("rst_perr", 64'(bus.proto_err_o), 64'd0);
        bus.valid_i = 1'b0;
        bus.sop_i   = 1'b0;
        bus.eop_i   = 1'b0;
        rst_n       = 1'b1;
        next_cycle();
        check_output("post_rst_valid", 64'(bus.valid_o), 64'd0);

        // Single-beat packet of 8 bits
        apply_stimulus(68'h4_0000_0000_0000_0000, 7'd8, 1'b1, 1'b1);
        check_output("t2_valid", 64'(bus.valid_o), 64'd1);
        check_output("t2_data", bus.data_o, 64'h4000_0000_0000_0000);
        check_output("t2_sop", 64'(bus.sop_o), 64'd1);
        check_output("t2_eop", 64'(bus.eop_o), 64'd1);
        check_output("t2_bits", 64'(bus.bits_o), 64'd8);
        next_cycle();
        check_output("t2_one_cycle", 64'(bus.valid_o), 64'd0);

        // Eight 8-bit beats fill exactly one word
        for (int i = 0; i < 8; i++)
            apply_stimulus(68'hA_B000_0000_0000_0000, 7'd8, i == 0, i == 7);
        check_output("t3_data", bus.data_o, 64'hABAB_ABAB_ABAB_ABAB);
        check_output("t3_bits", 64'(bus.bits_o), 64'd64);
        check_output("t3_sop", 64'(bus.sop_o), 64'd1);
        check_output("t3_eop", 64'(bus.eop_o), 64'd1);
        next_cycle();
        check_output("t3_no_pad", 64'(bus.valid_o), 64'd0);

        // 66 + 66 bits spill into a third, padded word
        apply_stimulus({CODE_W{1'b1}}, 7'd66, 1'b1, 1'b0);
        check_output("t4_w0_data", bus.data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check_output("t4_w0_bits", 64'(bus.bits_o), 64'd64);
        check_output("t4_w0_sop", 64'(bus.sop_o), 64'd1);
        check_output("t4_w0_eop", 64'(bus.eop_o), 64'd0);
        apply_stimulus({CODE_W{1'b1}}, 7'd66, 1'b0, 1'b1);
        check_output("t4_w1_data", bus.data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check_output("t4_w1_bits", 64'(bus.bits_o), 64'd64);
        check_output("t4_w1_sop", 64'(bus.sop_o), 64'd0);
        check_output("t4_w1_eop", 64'(bus.eop_o), 64'd0);
        next_cycle();
        check_output("t4_w2_data", bus.data_o, 64'hF000_0000_0000_0000);
        check_output("t4_w2_bits", 64'(bus.bits_o), 64'd4);
        check_output("t4_w2_eop", 64'(bus.eop_o), 64'd1);
        next_cycle();
        check_output("t4_done", 64'(bus.valid_o), 64'd0);

        // Back-pressure, headroom and overflow
        do_reset();
        bus.ready_i = 1'b0;
        apply_stimulus(68'h1_1111_1111_1111_1111, 7'd68, 1'b0, 1'b0);
        check_output("t5_ready_68", 64'(bus.ready_o), 64'd1);
        apply_stimulus(68'h2_2222_2222_2222_2222, 7'd68, 1'b0, 1'b0);
        check_output("t5_ready_136", 64'(bus.ready_o), 64'd0);
        apply_stimulus(68'h3_3333_3333_3333_3333, 7'd68, 1'b0, 1'b0);
        check_output("t5_ovf_204", 64'(bus.overflow_o), 64'd0);
        apply_stimulus(68'h4_4444_4444_4444_4444, 7'd68, 1'b0, 1'b0);
        check_output("t5_ovf_set", 64'(bus.overflow_o), 64'd1);
        check_output("t5_hold_data", bus.data_o, 64'h1111_1111_1111_1111);
        bus.ready_i = 1'b1;
        next_cycle();
        check_output("t5_w1", bus.data_o, 64'h1222_2222_2222_2222);
        next_cycle();
        check_output("t5_w2", bus.data_o, 64'h2233_3333_3333_3333);
        next_cycle();
        check_output("t5_drained", 64'(bus.valid_o), 64'd0);
        check_output("t5_ready_back", 64'(bus.ready_o), 64'd1);
        apply_stimulus('0, 7'd0, 1'b0, 1'b1);
        check_output("t5_tail_data", bus.data_o, 64'h3330_0000_0000_0000);
        check_output("t5_tail_bits", 64'(bus.bits_o), 64'd12);
        check_output("t5_tail_eop", 64'(bus.eop_o), 64'd1);
        check_output("t5_ovf_sticky", 64'(bus.overflow_o), 64'd1);

        // sop on an unaligned fill
        do_reset();
        check_output("t6_ovf_cleared", 64'(bus.overflow_o), 64'd0);
        apply_stimulus(68'hA_B000_0000_0000_0000, 7'd8, 1'b1, 1'b0);
        check_output("t6_perr_aligned", 64'(bus.proto_err_o), 64'd0);
        apply_stimulus(68'hC_D000_0000_0000_0000, 7'd8, 1'b1, 1'b0);
        check_output("t6_perr_set", 64'(bus.proto_err_o), 64'd1);
        apply_stimulus(68'h1_2345_6789_ABC0_0000, 7'd48, 1'b0, 1'b1);
        check_output("t6_data", bus.data_o, 64'hABCD_1234_5678_9ABC);
        check_output("t6_bits", 64'(bus.bits_o), 64'd64);
        check_output("t6_eop", 64'(bus.eop_o), 64'd1);
        next_cycle();
        apply_stimulus('0, 7'd0, 1'b0, 1'b1);
        check_output("t6_empty_eop", 64'(bus.valid_o), 64'd0);
        check_output("t6_perr_sticky", 64'(bus.proto_err_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
